edl_delay_tuner: RTL and testbench

Synchronous tuning controller for a group of error-detecting-latch (EDL) pipeline stages. It counts timing-error events reported by the stages over fixed observation windows and steps the shared delay-line setting with a req/ack handshake: up when errors are frequent, down after sustained error-free operation. It also keeps a lifetime error statistic. It sits beside the asynchronous stage controllers and drives the delay-line configuration register that sets the matched delay.

---
 rtl/edl_delay_tuner.sv | 106 ++++++++++
 tb/tb_edl_delay_tuner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/edl_delay_tuner.sv
// edl_delay_tuner: windowed EDL error counter that steps a shared delay-line code via req/ack
module edl_delay_tuner #(
  parameter int NSTAGE     = 4,
  parameter int CODE_W     = 4,
  parameter int WINDOW     = 64,
  parameter int ERR_HI     = 3,
  parameter int QUIET_WIN  = 2,
  parameter int CODE_RESET = 8,
  parameter int CODE_MIN   = 1,
  parameter int CODE_MAX   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NSTAGE-1:0] err,
  output logic              cfg_req,
  output logic [CODE_W-1:0] cfg_code,
  input  logic              cfg_ack,
  output logic [CODE_W-1:0] code_out,
  output logic [15:0]       err_total,
  input  logic              clr_stats,
  output logic              at_max,
  output logic              at_min,
  output logic              busy
);
  localparam int WC_W = $clog2(WINDOW + 1);
  localparam int QW = $clog2(QUIET_WIN + 1);
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW - 1);
  localparam logic [QW-1:0] Q_LAST = QW'(QUIET_WIN);
  localparam logic [7:0] HI = 8'(ERR_HI);
  localparam logic [CODE_W-1:0] C_RST = CODE_W'(CODE_RESET);
  localparam logic [CODE_W-1:0] C_MIN = CODE_W'(CODE_MIN);
  localparam logic [CODE_W-1:0] C_MAX = CODE_W'(CODE_MAX);
  typedef enum logic [1:0] {IDLE, COUNT, DECIDE, APPLY} state_t;
  state_t state, state_nx;
  logic [WC_W-1:0] win_cnt;
  logic [7:0] win_err, pop, win_err_nx;
  logic [8:0] win_sum;
  logic [16:0] tot_sum;
  logic [QW-1:0] quiet_cnt, quiet_nx;
  logic hi, zero, up, dn;
  always_comb begin
    pop = '0;
    for (int i = 0; i < NSTAGE; i++) pop = pop + 8'(err[i]);
    win_sum = {1'b0, win_err} + {1'b0, pop};
    win_err_nx = win_sum[8] ? 8'hFF : win_sum[7:0];
    tot_sum = {1'b0, err_total} + {9'b0, pop};
    hi = win_err >= HI;
    zero = win_err == 8'd0;
    quiet_nx = quiet_cnt == Q_LAST ? quiet_cnt : quiet_cnt + 1'b1;
    up = hi && code_out < C_MAX;
    dn = zero && quiet_nx == Q_LAST && code_out > C_MIN;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = en ? COUNT : IDLE;
      COUNT:   state_nx = !en ? IDLE : win_cnt == WIN_LAST ? DECIDE : COUNT;
      DECIDE:  state_nx = (up || dn) ? APPLY : COUNT;
      APPLY:   state_nx = !cfg_ack ? APPLY : en ? COUNT : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    at_max = code_out == C_MAX;
    at_min = code_out == C_MIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
      win_err <= '0;
      quiet_cnt <= '0;
      code_out <= C_RST;
      cfg_code <= C_RST;
      cfg_req <= 1'b0;
      err_total <= '0;
    end else begin
      err_total <= clr_stats ? 16'(pop) : tot_sum[16] ? 16'hFFFF : tot_sum[15:0];
      case (state)
        COUNT: begin
          win_cnt <= en ? win_cnt + 1'b1 : '0;
          win_err <= en ? win_err_nx : '0;
        end
        DECIDE: begin
          win_cnt <= '0;
          win_err <= '0;
          quiet_cnt <= (zero && !dn) ? quiet_nx : '0;
          cfg_req <= up || dn;
          if (up) cfg_code <= code_out + 1'b1;
          else if (dn) cfg_code <= code_out - 1'b1;
        end
        APPLY: begin
          if (cfg_ack) code_out <= cfg_code;
          if (cfg_ack) cfg_req <= 1'b0;
        end
        default: begin
          win_cnt <= '0;
          win_err <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_edl_delay_tuner.sv
// tb_edl_delay_tuner: random and directed stimulus against a window-queue reference model
module tb_edl_delay_tuner;
  localparam int WINDOW = 64;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, cfg_ack = 1'b0, clr_stats = 1'b0;
  logic [3:0] err = '0;
  logic cfg_req, at_max, at_min, busy;
  logic [3:0] cfg_code, code_out;
  logic [15:0] err_total;
  int chk_cnt = 0, pass_cnt = 0;
  localparam int P_OFF = 0, P_WIN = 1, P_JUDGE = 2, P_CFG = 3;
  int m_code = 8, m_pend = 8, m_req = 0, m_total = 0, m_quiet = 0, m_phase = P_OFF;
  int win_q[$];

  edl_delay_tuner dut (
    .clk(clk), .rst(rst), .en(en), .err(err), .cfg_req(cfg_req), .cfg_code(cfg_code),
    .cfg_ack(cfg_ack), .code_out(code_out), .err_total(err_total), .clr_stats(clr_stats),
    .at_max(at_max), .at_min(at_min), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else pass_cnt++;
  endtask

  task automatic model_step();
    int p, s;
    p = $countones(err);
    if (rst) begin
      m_code = 8; m_pend = 8; m_req = 0; m_total = 0; m_quiet = 0; m_phase = P_OFF;
      win_q.delete();
      return;
    end
    m_total = clr_stats ? p : (m_total + p > 65535 ? 65535 : m_total + p);
    if (m_phase == P_OFF) begin
      if (en) m_phase = P_WIN;
    end else if (m_phase == P_WIN) begin
      if (!en) begin
        m_phase = P_OFF;
        win_q.delete();
      end else begin
        win_q.push_back(p);
        if (win_q.size() == WINDOW) m_phase = P_JUDGE;
      end
    end else if (m_phase == P_JUDGE) begin
      s = 0;
      foreach (win_q[k]) s += win_q[k];
      if (s > 255) s = 255;
      win_q.delete();
      m_phase = P_WIN;
      if (s >= 3) begin
        m_quiet = 0;
        if (m_code < 15) begin m_pend = m_code + 1; m_req = 1; m_phase = P_CFG; end
      end else if (s == 0) begin
        m_quiet++;
        if (m_quiet >= 2 && m_code > 1) begin
          m_pend = m_code - 1; m_quiet = 0; m_req = 1; m_phase = P_CFG;
        end
      end else m_quiet = 0;
    end else if (cfg_ack) begin
      m_code = m_pend;
      m_req = 0;
      m_phase = en ? P_WIN : P_OFF;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("code_out", code_out, m_code);
    chk("cfg_req", cfg_req, m_req);
    chk("cfg_code", cfg_code, m_pend);
    chk("err_total", err_total, m_total);
    chk("busy", busy, m_phase != P_OFF);
    chk("at_max", at_max, m_code == 15);
    chk("at_min", at_min, m_code == 1);
  endtask

  task automatic run_rand(input int n, input int dens, input bit allow_rst);
    for (int i = 0; i < n; i++) begin
      en = $urandom_range(0, 199) != 0;
      err = ($urandom_range(0, 999) < dens) ? 4'($urandom) : 4'h0;
      cfg_ack = $urandom_range(0, 3) == 0;
      clr_stats = $urandom_range(0, 499) == 0;
      rst = allow_rst && $urandom_range(0, 4999) == 0;
      cycle();
    end
    rst = 0; clr_stats = 0; cfg_ack = 0; err = 0; en = 1;
  endtask

  task automatic reach_apply();
    en = 1; err = 4'b1111;
    for (int i = 0; i < 65; i++) cycle();
    err = 0;
    for (int i = 0; i < 40 && !cfg_req; i++) cycle();
    chk("reach_apply_req", cfg_req, 1);
  endtask

  initial begin
    cycle(); cycle();
    chk("rst_code", code_out, 8);
    chk("rst_req", cfg_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_total", err_total, 0);
    rst = 0; en = 1;
    cycle();
    chk("en_busy", busy, 1);
    for (int i = 0; i < WINDOW; i++) begin
      err = (i == 5) ? 4'b0011 : (i == 40) ? 4'b0100 : 4'b0000;
      cycle();
    end
    err = 0;
    cycle();
    chk("inc_req", cfg_req, 1);
    chk("inc_code", cfg_code, 9);
    cycle(); cycle();
    cfg_ack = 1;
    cycle();
    cfg_ack = 0;
    chk("inc_applied", code_out, 9);
    chk("inc_req_low", cfg_req, 0);
    for (int i = 0; i < 2 * (WINDOW + 1); i++) cycle();
    chk("dec_req", cfg_req, 1);
    chk("dec_code", cfg_code, 8);
    cfg_ack = 1;
    cycle();
    cfg_ack = 0;
    run_rand(3000, 500, 0);
    chk("sat_max", at_max, 1);
    run_rand(5000, 0, 0);
    chk("sat_min", at_min, 1);
    run_rand(6000, 30, 1);
    rst = 1; cycle(); rst = 0;
    reach_apply();
    en = 0;
    cycle(); cycle(); cycle();
    chk("endrop_req_held", cfg_req, 1);
    cfg_ack = 1;
    cycle();
    cfg_ack = 0;
    chk("endrop_code", code_out, 9);
    chk("endrop_idle", busy, 0);
    rst = 1; cycle(); rst = 0;
    reach_apply();
    rst = 1;
    cycle();
    rst = 0;
    chk("rst_apply_req", cfg_req, 0);
    chk("rst_apply_code", code_out, 8);
    en = 0; err = 4'b1111;
    for (int i = 0; i < 17000; i++) cycle();
    chk("total_sat", err_total, 16'hFFFF);
    clr_stats = 1; err = 4'b0001;
    cycle();
    clr_stats = 0; err = 0;
    chk("total_clr", err_total, 1);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
